data_mem_ctrl: RTL

Load/store controller that sits directly downstream of the single-cycle datapath's memory-request outputs and drives a word-wide synchronous RAM with per-byte write strobes. It accepts one byte, half or word request at a time and splits any access that crosses a word boundary into two RAM accesses. For loads it assembles the result and applies sign or zero extension. It also keeps a counter of split accesses.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/data_mem_ctrl_lsu_align.sv | 65 ++++++
 rtl/data_mem_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store controller.
//   LEN_*         : request length encodings (byte/half/word, 00 = none)
//   ctrl_state_t  : controller state encoding
//   mask_n()      : right-aligned byte mask for a request length
package mem_pkg;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_FIN,
    ST_RESP
  } ctrl_state_t;

  // LEN_NONE maps to a full word, matching how an unspecified load
  // length is interpreted.
  function automatic logic [3:0] mask_n(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 4'b0001;
      LEN_HALF: return 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lsu_align.sv
// lsu_align: combinational lane alignment for the load/store controller.
//   len, off     : effective access length and byte offset within word A
//   sign_ext     : sign-extend byte/half loads
//   st_data      : right-aligned store data
//   rd_word_a/b  : RAM words A and B for load assembly (B = 0 if unused)
//   split        : access crosses into word B
//   wdata_a/b,
//   wstrb_a/b    : lane-aligned write data and byte strobes for A and B
//   ld_data      : assembled and extended load result
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  len,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word_a,
  input  logic [31:0] rd_word_b,
  output logic        split,
  output logic [31:0] wdata_a,
  output logic [31:0] wdata_b,
  output logic [3:0]  wstrb_a,
  output logic [3:0]  wstrb_b,
  output logic [31:0] ld_data
);

  logic [3:0]  mask;
  logic [2:0]  nbytes;
  logic [31:0] data_masked;
  logic [7:0]  strb_pair;
  logic [63:0] wdata_pair;
  logic [31:0] rd_shift;

  assign mask = mask_n(len);

  // Clear bytes beyond the access length so lanes without a strobe
  // always carry zero after shifting.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign data_masked[8*gi +: 8] = mask[gi] ? st_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    nbytes = (len == LEN_BYTE) ? 3'd1 : (len == LEN_HALF) ? 3'd2 : 3'd4;
    split  = ({1'b0, off} + nbytes) > 3'd4;

    // Shifting into a 2-word window puts word A lanes in the low half
    // and the overflow lanes for word B in the high half.
    strb_pair  = {4'b0000, mask} << off;
    wdata_pair = {32'h0, data_masked} << {off, 3'b000};
    wstrb_a    = strb_pair[3:0];
    wstrb_b    = strb_pair[7:4];
    wdata_a    = wdata_pair[31:0];
    wdata_b    = wdata_pair[63:32];

    rd_shift = 32'({rd_word_b, rd_word_a} >> {off, 3'b000});
    case (len)
      LEN_BYTE: ld_data = {{24{sign_ext & rd_shift[7]}},  rd_shift[7:0]};
      LEN_HALF: ld_data = {{16{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
      default:  ld_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte/half/word load/store controller in front of a
// word-wide synchronous RAM with byte strobes. Word-crossing accesses are
// split into two RAM accesses (word A, then word A+1 with wrap).
//   SYS_clk, SYS_reset         : clock, synchronous active-high reset
//   req_valid / req_ready      : request handshake (accept on both high)
//   MEM_write_length           : 00 = load, else byte/half/word store
//   MEM_read_length/_signed    : load length (00 = word) and extension
//   MEM_write_data/_address    : store data (right-aligned) and address
//   MEM_read_address           : load address
//   resp_valid, MEM_read_data  : one-cycle completion pulse and load data
//   ram_*                      : registered RAM port; ram_rdata returns
//                                one cycle after a read
//   split_count                : number of accepted split requests
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        MEM_write_length,
  input  logic [1:0]        MEM_read_length,
  input  logic              MEM_read_signed,
  input  logic [31:0]       MEM_write_data,
  input  logic [31:0]       MEM_write_address,
  input  logic [31:0]       MEM_read_address,
  output logic              resp_valid,
  output logic [31:0]       MEM_read_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wstrb,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [CNT_W-1:0]  split_count
);

  ctrl_state_t       state_reg;
  logic              is_store_reg;
  logic              split_reg;
  logic              sign_reg;
  logic [1:0]        len_reg;
  logic [1:0]        off_reg;
  logic [ADDR_W-1:0] widx_reg;
  logic [31:0]       data_reg;
  logic [31:0]       word_a_reg;

  logic        req_store;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [1:0]  cur_len;
  logic [1:0]  cur_off;
  logic        cur_sign;
  logic [31:0] cur_data;
  logic [31:0] rd_word_a;
  logic [31:0] rd_word_b;

  logic        al_split;
  logic [31:0] al_wdata_a;
  logic [31:0] al_wdata_b;
  logic [3:0]  al_wstrb_a;
  logic [3:0]  al_wstrb_b;
  logic [31:0] al_ld_data;

  // Only the word index and byte offset of the address are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state_reg == ST_IDLE);

  always_comb begin
    req_store = (MEM_write_length != LEN_NONE);
    req_addr  = req_store ? MEM_write_address : MEM_read_address;
    req_len   = LEN_WORD;
    if (req_store)
      req_len = MEM_write_length;
    else if (MEM_read_length != LEN_NONE)
      req_len = MEM_read_length;

    // The aligner sees the live request while idle (word A lanes are
    // registered on the accept edge) and the latched copy afterwards.
    if (state_reg == ST_IDLE) begin
      cur_len  = req_len;
      cur_off  = req_addr[1:0];
      cur_sign = MEM_read_signed;
      cur_data = MEM_write_data;
    end else begin
      cur_len  = len_reg;
      cur_off  = off_reg;
      cur_sign = sign_reg;
      cur_data = data_reg;
    end

    // In FIN the RAM output holds the last word read: word A for an
    // aligned load, word B for a split one.
    rd_word_a = split_reg ? word_a_reg : ram_rdata;
    rd_word_b = split_reg ? ram_rdata  : 32'h0;
  end

  lsu_align u_align (
    .len       (cur_len),
    .off       (cur_off),
    .sign_ext  (cur_sign),
    .st_data   (cur_data),
    .rd_word_a (rd_word_a),
    .rd_word_b (rd_word_b),
    .split     (al_split),
    .wdata_a   (al_wdata_a),
    .wdata_b   (al_wdata_b),
    .wstrb_a   (al_wstrb_a),
    .wstrb_b   (al_wstrb_b),
    .ld_data   (al_ld_data)
  );

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_reg     <= ST_IDLE;
      is_store_reg  <= 1'b0;
      split_reg     <= 1'b0;
      sign_reg      <= 1'b0;
      len_reg       <= LEN_NONE;
      off_reg       <= 2'b00;
      widx_reg      <= '0;
      data_reg      <= 32'h0;
      word_a_reg    <= 32'h0;
      resp_valid    <= 1'b0;
      MEM_read_data <= 32'h0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wstrb     <= 4'h0;
      ram_wdata     <= 32'h0;
      split_count   <= '0;
    end else begin
      // RAM strobes and the response are single-cycle pulses.
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_wstrb  <= 4'h0;
      ram_wdata  <= 32'h0;
      resp_valid <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            is_store_reg <= req_store;
            split_reg    <= al_split;
            sign_reg     <= MEM_read_signed;
            len_reg      <= req_len;
            off_reg      <= req_addr[1:0];
            widx_reg     <= req_addr[ADDR_W+1:2];
            data_reg     <= MEM_write_data;
            ram_en       <= 1'b1;
            ram_we       <= req_store;
            ram_addr     <= req_addr[ADDR_W+1:2];
            if (req_store) begin
              ram_wstrb <= al_wstrb_a;
              ram_wdata <= al_wdata_a;
            end
            if (al_split)
              split_count <= split_count + CNT_W'(1);
            state_reg <= ST_ACC0;
          end
        end

        ST_ACC0: begin
          if (split_reg) begin
            ram_en   <= 1'b1;
            ram_we   <= is_store_reg;
            ram_addr <= widx_reg + ADDR_W'(1);
            if (is_store_reg) begin
              ram_wstrb <= al_wstrb_b;
              ram_wdata <= al_wdata_b;
            end
            state_reg <= ST_ACC1;
          end else if (is_store_reg) begin
            resp_valid    <= 1'b1;
            MEM_read_data <= 32'h0;
            state_reg     <= ST_RESP;
          end else begin
            state_reg <= ST_FIN;
          end
        end

        ST_ACC1: begin
          word_a_reg <= ram_rdata;
          if (is_store_reg) begin
            resp_valid    <= 1'b1;
            MEM_read_data <= 32'h0;
            state_reg     <= ST_RESP;
          end else begin
            state_reg <= ST_FIN;
          end
        end

        ST_FIN: begin
          MEM_read_data <= al_ld_data;
          resp_valid    <= 1'b1;
          state_reg     <= ST_RESP;
        end

        ST_RESP: state_reg <= ST_IDLE;

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
